// File: rtl/cordic_rot_iter.sv
// Iterative rotation-mode CORDIC: (mag, phase) -> (mag*cos, mag*sin), one micro-rotation per clock.
// Optional 1/K gain compensation stage enabled by defining CORDIC_ROT_GAIN_COMP_EN.
module cordic_rot_iter #(
    parameter int ITER = 12,
    parameter int W    = 32
) (
    input  logic                rx_clk,
    input  logic                rx_rst,
    input  logic                rx_start,
    input  logic [11:0]         rx_phase,
    input  logic signed [W-1:0] rx_mag,
    output logic                tx_busy,
    output logic                tx_valid,
    output logic signed [W-1:0] tx_cos,
    output logic signed [W-1:0] tx_sin
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        GAIN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [3:0]          cnt_r, cnt_s;
    logic signed [W-1:0] x_r, x_s, y_r, y_s;
    logic signed [11:0]  z_r, z_s;
    logic signed [W-1:0] cos_r, cos_s, sin_r, sin_s;
    logic                valid_r, valid_s;
    logic                busy_r, busy_s;
    logic signed [W-1:0] x_sh_s, y_sh_s;

    // Arctangent table in phase units of 2*pi/4096
    function automatic logic signed [11:0] atan_lut(input logic [3:0] idx);
        logic signed [11:0] a;
        case (idx)
            4'd0:    a = 12'sd512;
            4'd1:    a = 12'sd302;
            4'd2:    a = 12'sd160;
            4'd3:    a = 12'sd81;
            4'd4:    a = 12'sd41;
            4'd5:    a = 12'sd20;
            4'd6:    a = 12'sd10;
            4'd7:    a = 12'sd5;
            4'd8:    a = 12'sd3;
            4'd9:    a = 12'sd1;
            4'd10:   a = 12'sd1;
            default: a = 12'sd0;
        endcase
        return a;
    endfunction

`ifdef CORDIC_ROT_GAIN_COMP_EN
    // Shift-add approximation of 1/K = 0.60725...
    function automatic logic signed [W-1:0] gain_scale(input logic signed [W-1:0] v);
        return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9);
    endfunction
`endif

    assign x_sh_s = x_r >>> cnt_r;
    assign y_sh_s = y_r >>> cnt_r;

    // Next-state, datapath and output computation
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        x_s     = x_r;
        y_s     = y_r;
        z_s     = z_r;
        cos_s   = cos_r;
        sin_s   = sin_r;
        valid_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (rx_start) begin
                    case (rx_phase[11:10])
                        2'b00: begin
                            x_s = rx_mag;
                            y_s = {W{1'b0}};
                        end
                        2'b01: begin
                            x_s = {W{1'b0}};
                            y_s = rx_mag;
                        end
                        2'b10: begin
                            x_s = -rx_mag;
                            y_s = {W{1'b0}};
                        end
                        default: begin
                            x_s = {W{1'b0}};
                            y_s = -rx_mag;
                        end
                    endcase
                    z_s     = {2'b00, rx_phase[9:0]};
                    cnt_s   = 4'd0;
                    state_s = ROT;
                end else begin
                    state_s = IDLE;
                end
            end
            ROT: begin
                if (z_r[11]) begin
                    x_s = x_r + y_sh_s;
                    y_s = y_r - x_sh_s;
                    z_s = z_r + atan_lut(cnt_r);
                end else begin
                    x_s = x_r - y_sh_s;
                    y_s = y_r + x_sh_s;
                    z_s = z_r - atan_lut(cnt_r);
                end
                if (cnt_r == 4'(ITER - 1)) begin
`ifdef CORDIC_ROT_GAIN_COMP_EN
                    state_s = GAIN;
`else
                    state_s = DONE;
`endif
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
`ifdef CORDIC_ROT_GAIN_COMP_EN
            GAIN: begin
                x_s     = gain_scale(x_r);
                y_s     = gain_scale(y_r);
                state_s = DONE;
            end
`endif
            DONE: begin
                cos_s   = x_r;
                sin_s   = y_r;
                valid_s = 1'b1;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Busy stays up through the result cycle so it drops one edge after tx_valid rises
    assign busy_s = (state_s != IDLE) || (state_r == DONE);

    // State and datapath registers with synchronous reset
    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            x_r     <= {W{1'b0}};
            y_r     <= {W{1'b0}};
            z_r     <= 12'sd0;
            cos_r   <= {W{1'b0}};
            sin_r   <= {W{1'b0}};
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            x_r     <= x_s;
            y_r     <= y_s;
            z_r     <= z_s;
            cos_r   <= cos_s;
            sin_r   <= sin_s;
            valid_r <= valid_s;
            busy_r  <= busy_s;
        end
    end

    assign tx_busy  = busy_r;
    assign tx_valid = valid_r;
    assign tx_cos   = cos_r;
    assign tx_sin   = sin_r;

endmodule

// File: tb/tb_cordic_rot_iter.sv
// Scoreboard bench for cordic_rot_iter: bit-exact reference model plus real-valued sanity checks.
module tb_cordic_rot_iter;

    localparam int ITER = 12;
    localparam int W    = 32;
`ifdef CORDIC_ROT_GAIN_COMP_EN
    localparam int  LAT = ITER + 2;
    localparam real KG  = 1.000278;
`else
    localparam int  LAT = ITER + 1;
    localparam real KG  = 1.646760;
`endif

    logic                rx_clk = 1'b0;
    logic                rx_rst;
    logic                rx_start;
    logic [11:0]         rx_phase;
    logic signed [W-1:0] rx_mag;
    logic                tx_busy;
    logic                tx_valid;
    logic signed [W-1:0] tx_cos;
    logic signed [W-1:0] tx_sin;

    typedef struct {
        logic signed [W-1:0] c;
        logic signed [W-1:0] s;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;
    int   n_valid = 0;
    logic prev_valid = 1'b0;

    cordic_rot_iter #(.ITER(ITER), .W(W)) dut (
        .rx_clk   (rx_clk),
        .rx_rst   (rx_rst),
        .rx_start (rx_start),
        .rx_phase (rx_phase),
        .rx_mag   (rx_mag),
        .tx_busy  (tx_busy),
        .tx_valid (tx_valid),
        .tx_cos   (tx_cos),
        .tx_sin   (tx_sin)
    );

    always #5 rx_clk = ~rx_clk;

    task automatic model(input logic [11:0] ph, input logic signed [W-1:0] m,
                         output logic signed [W-1:0] c, output logic signed [W-1:0] s);
        logic signed [W-1:0] x, y, xn;
        logic signed [11:0]  z;
        int atab [12];
        atab = '{512, 302, 160, 81, 41, 20, 10, 5, 3, 1, 1, 0};
        case (ph[11:10])
            2'b00:   begin x = m;  y = 0;  end
            2'b01:   begin x = 0;  y = m;  end
            2'b10:   begin x = -m; y = 0;  end
            default: begin x = 0;  y = -m; end
        endcase
        z = {2'b00, ph[9:0]};
        for (int i = 0; i < ITER; i++) begin
            if (z[11] == 1'b0) begin
                xn = x - (y >>> i);
                y  = y + (x >>> i);
                z  = z - 12'(atab[i]);
            end else begin
                xn = x + (y >>> i);
                y  = y - (x >>> i);
                z  = z + 12'(atab[i]);
            end
            x = xn;
        end
`ifdef CORDIC_ROT_GAIN_COMP_EN
        x = (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9);
        y = (y >>> 1) + (y >>> 3) - (y >>> 6) - (y >>> 9);
`endif
        c = x;
        s = y;
    endtask

    // Push the expected result, then pulse start for one cycle (DUT assumed idle)
    task automatic issue(input logic [11:0] ph, input logic signed [W-1:0] m);
        exp_t e;
        model(ph, m, e.c, e.s);
        sb.push_back(e);
        rx_phase = ph;
        rx_mag   = m;
        rx_start = 1'b1;
        @(posedge rx_clk);
        #1;
        rx_start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (tx_busy && n < 60) begin
            @(posedge rx_clk);
            #1;
            n++;
        end
        if (tx_busy) begin
            vectors++;
            errors++;
            $display("FAIL idle_timeout: busy=%0b after %0d cycles, required 0", tx_busy, n);
        end
        @(posedge rx_clk);
        #1;
    endtask

    // Scoreboard: every tx_valid pulse pops one expected result
    always @(negedge rx_clk) begin
        exp_t e;
        if (tx_valid) begin
            n_valid++;
            vectors++;
            if (prev_valid) begin
                errors++;
                $display("FAIL valid_width: tx_valid high on consecutive cycles, required single pulse");
            end
            if (sb.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_valid: tx_valid with empty scoreboard, cos=%0d sin=%0d", tx_cos, tx_sin);
            end else begin
                e = sb.pop_front();
                vectors++;
                if (tx_cos !== e.c) begin
                    errors++;
                    $display("FAIL cos: got %0d expected %0d", tx_cos, e.c);
                end
                vectors++;
                if (tx_sin !== e.s) begin
                    errors++;
                    $display("FAIL sin: got %0d expected %0d", tx_sin, e.s);
                end
            end
        end
        prev_valid = tx_valid;
    end

    task automatic test_reset();
        rx_rst   = 1'b1;
        rx_start = 1'b0;
        rx_phase = 12'd0;
        rx_mag   = 32'sd0;
        repeat (3) @(posedge rx_clk);
        #1;
        vectors++; if (tx_busy !== 1'b0)   begin errors++; $display("FAIL rst_busy: got %b expected 0", tx_busy); end
        vectors++; if (tx_valid !== 1'b0)  begin errors++; $display("FAIL rst_valid: got %b expected 0", tx_valid); end
        vectors++; if (tx_cos !== 32'sd0)  begin errors++; $display("FAIL rst_cos: got %0d expected 0", tx_cos); end
        vectors++; if (tx_sin !== 32'sd0)  begin errors++; $display("FAIL rst_sin: got %0d expected 0", tx_sin); end
        rx_rst = 1'b0;
        @(posedge rx_clk);
        #1;
    endtask

    task automatic test_latency();
        int  valid_at, busy_cnt;
        real ref_v, err;
        issue(12'd0, 32'sd1000000);
        valid_at = -1;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin
                @(posedge rx_clk);
                #1;
            end
            if (tx_busy) busy_cnt++;
            if (tx_valid && valid_at < 0) valid_at = i;
        end
        vectors++; if (valid_at != LAT)     begin errors++; $display("FAIL latency: got %0d edges expected %0d", valid_at, LAT); end
        vectors++; if (busy_cnt != LAT + 1) begin errors++; $display("FAIL busy_len: got %0d cycles expected %0d", busy_cnt, LAT + 1); end
        // outputs must still hold the result several cycles after the pulse
        ref_v = 1000000.0 * KG;
        err = $itor(tx_cos) - ref_v;
        if (err < 0.0) err = -err;
        vectors++; if (err > 0.01 * ref_v) begin errors++; $display("FAIL cos_accuracy: got %0d expected about %0d", tx_cos, $rtoi(ref_v)); end
        err = $itor(tx_sin);
        if (err < 0.0) err = -err;
        vectors++; if (err > 0.01 * ref_v) begin errors++; $display("FAIL sin_accuracy: got %0d expected about 0", tx_sin); end
    endtask

    task automatic test_quadrants();
        logic [11:0] ph_tab [5];
        ph_tab = '{12'd1024, 12'd2048, 12'd3072, 12'd333, 12'd3900};
        for (int i = 0; i < 5; i++) begin
            issue(ph_tab[i], 32'sd1000000);
            wait_idle();
        end
        for (int i = 0; i < 4; i++) begin
            issue(12'($urandom_range(4095, 0)), 32'(int'($urandom_range(1073741822, 0)) - 536870911));
            wait_idle();
        end
    endtask

    task automatic test_neg_mag();
        real ref_v, err;
        issue(12'd512, -32'sd500000);
        wait_idle();
        ref_v = -500000.0 * KG * 0.70710678;
        err = $itor(tx_cos) - ref_v;
        if (err < 0.0) err = -err;
        vectors++; if (err > 0.01 * 500000.0 * KG) begin errors++; $display("FAIL neg_cos: got %0d expected about %0d", tx_cos, $rtoi(ref_v)); end
        err = $itor(tx_sin) - ref_v;
        if (err < 0.0) err = -err;
        vectors++; if (err > 0.01 * 500000.0 * KG) begin errors++; $display("FAIL neg_sin: got %0d expected about %0d", tx_sin, $rtoi(ref_v)); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   idx [3];
        int   n;
        model(12'd100, 32'sd777777, e.c, e.s);
        for (int i = 0; i < 3; i++) sb.push_back(e);
        rx_phase = 12'd100;
        rx_mag   = 32'sd777777;
        rx_start = 1'b1;
        n = 0;
        for (int i = 1; i <= 100 && n < 3; i++) begin
            @(posedge rx_clk);
            #1;
            if (tx_valid) begin
                idx[n] = i;
                n++;
            end
        end
        rx_start = 1'b0;
        vectors++;
        if (n != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d results expected 3", n);
        end else begin
            if (idx[0] != LAT + 1) begin errors++; $display("FAIL b2b_first: got edge %0d expected %0d", idx[0], LAT + 1); end
            vectors++; if (idx[1] - idx[0] != LAT + 1) begin errors++; $display("FAIL b2b_period1: got %0d expected %0d", idx[1] - idx[0], LAT + 1); end
            vectors++; if (idx[2] - idx[1] != LAT + 1) begin errors++; $display("FAIL b2b_period2: got %0d expected %0d", idx[2] - idx[1], LAT + 1); end
        end
        wait_idle();
    endtask

    task automatic test_mid_reset();
        int nv;
        issue(12'd700, 32'sd123456);
        repeat (5) @(posedge rx_clk);
        #1;
        rx_rst = 1'b1;
        @(posedge rx_clk);
        #1;
        rx_rst = 1'b0;
        vectors++; if (tx_busy !== 1'b0)  begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", tx_busy); end
        vectors++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", tx_valid); end
        vectors++; if (tx_cos !== 32'sd0) begin errors++; $display("FAIL mid_rst_cos: got %0d expected 0", tx_cos); end
        vectors++; if (tx_sin !== 32'sd0) begin errors++; $display("FAIL mid_rst_sin: got %0d expected 0", tx_sin); end
        sb.delete();
        nv = n_valid;
        repeat (20) @(posedge rx_clk);
        #1;
        vectors++; if (n_valid != nv) begin errors++; $display("FAIL mid_rst_pulse: got %0d pulses expected 0", n_valid - nv); end
        issue(12'd1500, -32'sd2000000);
        wait_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_quadrants();
        test_neg_mag();
        test_back_to_back();
        test_mid_reset();
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d expected results never produced, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/cordic_rot_iter.md
Name: cordic_rot_iter

Overview:
- Iterative rotation-mode CORDIC; inverse direction of the vectoring/atan stages.
- Takes a 12-bit phase and a signed magnitude; produces the rotated vector (mag·cos, mag·sin).
- Used for local carrier/NCO sin-cos generation and for re-rotating tracked vectors in the baseband loop.
- Single shared datapath; one iteration per clock; start/valid handshake.

Parameters:
- ITER, 12, number of micro-rotations (1..12); atan table index i = 0..ITER-1.
- W, 32, datapath width of x/y (signed).

Ports:
- rx_clk  input  1  clock
- rx_rst  input  1  synchronous reset, active-high
- rx_start  input  1  request; accepted only when tx_busy=0
- rx_phase  input  12  unsigned phase; full circle = 4096 (1 LSB = 2π/4096)
- rx_mag  input  W  signed magnitude; |rx_mag| < 2^(W-2) required
- tx_busy  output  1  high whenever state ≠ IDLE
- tx_valid  output  1  one-cycle pulse when results update
- tx_cos  output  W  signed x result
- tx_sin  output  W  signed y result

Behaviour:
- Reset (rx_rst=1 at rising edge): state=IDLE, tx_busy=0, tx_valid=0, tx_cos=0, tx_sin=0, iteration counter=0, x/y/z regs=0. Reset mid-operation abandons the computation; no tx_valid is issued.
- States: IDLE -> ROT -> (GAIN) -> DONE -> IDLE.
- IDLE: if rx_start=1 at edge k, latch operands with quadrant pre-rotation by rx_phase[11:10]:
  - 00: x=m, y=0
  - 01: x=0, y=m
  - 10: x=-m, y=0
  - 11: x=0, y=-m
  - In all cases z = {2'b00, rx_phase[9:0]} as signed 12-bit; cnt=0; go to ROT.
- ROT: one micro-rotation per edge, with s = z[11]:
  - s=0: x' = x - (y>>>cnt), y' = y + (x>>>cnt), z' = z - ATAN[cnt]
  - s=1: x' = x + (y>>>cnt), y' = y - (x>>>cnt), z' = z + ATAN[cnt]
  - Shifts are arithmetic; z wraps in 12 bits (no saturation).
  - After the rotation with cnt=ITER-1, go to DONE (or GAIN when the macro is defined); otherwise cnt++.
- ATAN table (2π/4096 units), i=0..11: 512, 302, 160, 81, 41, 20, 10, 5, 3, 1, 1, 0.
- DONE: tx_cos<=x, tx_sin<=y, tx_valid<=1 for exactly one cycle, then return to IDLE.
- Latency, no gain compensation: start sampled at edge k -> tx_valid high after edge k+ITER+1 -> tx_busy low after edge k+ITER+2. A start presented in that same cycle is accepted at edge k+ITER+2.
- rx_start while tx_busy=1 is ignored (not queued).
- tx_cos/tx_sin hold their last result until the next DONE.
- Output gain without compensation is K ≈ 1.646760 (ITER=12).
- No overflow inside the stated |rx_mag| range.

Optional Feature:
- Macro: CORDIC_ROT_GAIN_COMP_EN.
- Defined:
  - Adds state GAIN (one cycle) between ROT and DONE.
  - x and y are each scaled by 1/K using shift-add: v·(2^-1 + 2^-3 - 2^-6 - 2^-9), i.e. (v>>>1)+(v>>>3)-(v>>>6)-(v>>>9). Net gain ≈ 1.000278.
  - Latency becomes ITER+2 cycles to tx_valid.
- Undefined:
  - No GAIN state; outputs carry gain K.
  - Latency ITER+1 cycles to tx_valid.

Test Plan (ITER=12, W=32; tolerance ±1% of |mag·K|):
1. Reset -> rx_phase=0, rx_mag=1000000, one-cycle start -> tx_valid after exactly 13 edges; tx_cos≈1646760, tx_sin≈0; tx_busy high for 14 cycles.
2. Quadrants: phase=1024 / 2048 / 3072, mag=1000000 -> (cos,sin) ≈ (0,1646760) / (-1646760,0) / (0,-1646760).
3. Phase=512 (45°), mag=-500000 -> tx_cos≈tx_sin≈-582218; negative magnitude and arithmetic shifts are correct.
4. Start re-asserted on every cycle while busy -> exactly one result per 14 cycles; back-to-back restart accepted on the edge after tx_valid; tx_valid never lasts more than 1 cycle.
5. Assert rx_rst on the 6th ROT cycle -> next edge: tx_busy=0, tx_cos=tx_sin=0, no tx_valid pulse; a subsequent start completes normally.
6. With CORDIC_ROT_GAIN_COMP_EN defined: phase=0, mag=1000000 -> tx_cos≈1000278 (±1%), tx_valid after 14 edges.
